code_enroller: RTL and testbench

- Writer side of the CI-LOCKER password path: lets an already-unlocked user program a new multi-digit BCD code from SW and pushbuttons.
- The checker reads `code_out` as its reference password.
- Every new code is entered twice and is committed only if both entries match.
- Sits between the DE-2 keys/switches and the lock checker; runs on CLOCK_50.

---
 rtl/code_enroller.sv | 245 ++++++++++++++++++++++++
 tb/tb_code_enroller.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_enroller.sv
// code_enroller: writer side of the CI-LOCKER password path.
// An unlocked user enters a new BCD code twice from the switches; the code
// is committed to code_out only when both entries agree.
// Optional feature: define CODE_ENROLL_TIMEOUT_EN to abort an entry session
// after TIMEOUT_CYC cycles without an accepted digit.

module code_enroller #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter logic [31:0] DEFAULT_CODE = 32'h0000_1009,
  parameter int unsigned TIMEOUT_CYC  = 500000000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                key_prog,
  input  logic                key_enter,
  input  logic [3:0]          sw_digit,
  input  logic                unlock_ok,
  output logic [4*DIGITS-1:0] code_out,
  output logic                busy,
  output logic [1:0]          phase,
  output logic [2:0]          digit_idx,
  output logic                enroll_done,
  output logic                enroll_fail
);

  localparam int unsigned CODE_W = 4 * DIGITS;
  localparam int unsigned DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [2:0]      IDX_LAST = 3'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY1,
    S_ENTRY2,
    S_CHECK,
    S_COMMIT,
    S_FAIL
  } state_e;

  // ---------------------------------------------------------------------
  // Input synchronizers: bit 0 = key_prog, bit 1 = key_enter, [5:2] = sw
  // ---------------------------------------------------------------------
  logic [5:0] meta_q, meta_d;
  logic [5:0] sync_q, sync_d;

  // Two-stage synchronizer next values.
  always_comb begin
    meta_d = {sw_digit, key_enter, key_prog};
    sync_d = meta_q;
  end

  // Synchronizer flops; keys reset to their released (high) level.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; reset here is synchronous, sampled on the clock edge.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      meta_q <= 6'b000011;
      sync_q <= 6'b000011;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  // ---------------------------------------------------------------------
  // Debouncers (index 0 = prog, 1 = enter)
  // ---------------------------------------------------------------------
  logic [1:0]      deb_q, deb_d;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];
  logic            prog_pulse;
  logic            enter_pulse;
  logic [3:0]      digit;

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      deb_d[k] = deb_q[k];
      cnt_d[k] = '0;
      if (sync_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DB_LAST) begin
          deb_d[k] = sync_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Debounced levels and their stability counters.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      deb_q <= 2'b11;
      for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int k = 0; k < 2; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // A press is the cycle the debounced level falls; release is silent.
  assign prog_pulse  = deb_q[0] & ~deb_d[0];
  assign enter_pulse = deb_q[1] & ~deb_d[1];
  assign digit       = sync_q[5:2];

  // ---------------------------------------------------------------------
  // Enrollment FSM
  // ---------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CODE_W-1:0] a_q, a_d;
  logic [CODE_W-1:0] b_q, b_d;
  logic [2:0]        idx_q, idx_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              busy_q, busy_d;
  logic [1:0]        phase_q, phase_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              timed_out;

`ifdef CODE_ENROLL_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign timed_out = (tmo_q == TMO_LAST);

  // Inactivity counter: restarts on session start and on every enter press.
  always_comb begin
    tmo_d = '0;
    if ((state_q == S_ENTRY1 || state_q == S_ENTRY2) &&
        (state_d == S_ENTRY1 || state_d == S_ENTRY2) && !enter_pulse) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Inactivity counter register.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  // Next state, shadow-register writes and registered output values.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    code_d  = code_q;

    case (state_q)
      S_IDLE: begin
        if (prog_pulse) begin
          state_d = unlock_ok ? S_ENTRY1 : S_FAIL;
          idx_d   = '0;
        end
      end
      S_ENTRY1, S_ENTRY2: begin
        if (prog_pulse) begin
          state_d = S_FAIL;
        end else if (enter_pulse) begin
          if (digit > 4'd9) begin
            state_d = S_FAIL;
          end else begin
            for (int i = 0; i < int'(DIGITS); i++) begin
              if (idx_q == 3'(i)) begin
                if (state_q == S_ENTRY1) a_d[4*i +: 4] = digit;
                else                     b_d[4*i +: 4] = digit;
              end
            end
            if (idx_q == IDX_LAST) begin
              state_d = (state_q == S_ENTRY1) ? S_ENTRY2 : S_CHECK;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end else if (timed_out) begin
          state_d = S_FAIL;
          a_d     = '0;
          b_d     = '0;
        end
      end
      S_CHECK: begin
        if (a_q == b_q) begin
          state_d = S_COMMIT;
          code_d  = a_q;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_d != S_ENTRY1 && state_d != S_ENTRY2) idx_d = '0;

    busy_d  = (state_d != S_IDLE);
    phase_d = (state_d == S_ENTRY1) ? 2'd1 :
              (state_d == S_ENTRY2) ? 2'd2 : 2'd0;
    done_d  = (state_d == S_COMMIT);
    fail_d  = (state_d == S_FAIL);
  end

  // FSM state, shadow registers, committed code and output flops.
  // NOTE: the shadow registers are cleared at reset so a half-entered code
  // can never leak into a later comparison.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      code_q  <= DEFAULT_CODE[CODE_W-1:0];
      busy_q  <= 1'b0;
      phase_q <= 2'd0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign code_out    = code_q;
  assign busy        = busy_q;
  assign phase       = phase_q;
  assign digit_idx   = idx_q;
  assign enroll_done = done_q;
  assign enroll_fail = fail_q;

endmodule

// File: tb/tb_code_enroller.sv
// Self-checking bench for code_enroller: a behavioural model built from the
// enrollment rules (digit queues, run-length debounce) is compared against
// every output on every cycle, plus scenario-level literal expectations.

module tb_code_enroller;

  localparam int DIGITS = 4;
  localparam int DEB    = 4;
  localparam int TMO    = 100;
  localparam int CW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_prog;
  logic          key_enter;
  logic [3:0]    sw_digit;
  logic          unlock_ok;
  logic [CW-1:0] code_out;
  logic          busy;
  logic [1:0]    phase;
  logic [2:0]    digit_idx;
  logic          enroll_done;
  logic          enroll_fail;

  always #5 clk = ~clk;

  code_enroller #(
    .DIGITS       (DIGITS),
    .DEBOUNCE_CYC (DEB),
    .DEFAULT_CODE (32'h0000_1009),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .key_prog    (key_prog),
    .key_enter   (key_enter),
    .sw_digit    (sw_digit),
    .unlock_ok   (unlock_ok),
    .code_out    (code_out),
    .busy        (busy),
    .phase       (phase),
    .digit_idx   (digit_idx),
    .enroll_done (enroll_done),
    .enroll_fail (enroll_fail)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            cyc = 0;
  bit            m_valid = 1'b0;
  logic          key_pipe [2][2];   // [key][stage], stage 1 = synchronized
  logic [3:0]    sw_pipe  [2];
  logic          deb      [2];
  int            run      [2];
  bit            pr       [2];
  int            q1 [$];
  int            q2 [$];
  int            m_phase;
  bit            m_busy, m_done, m_fail, m_checking, m_finishing, m_eq;
  logic [CW-1:0] m_code;
  int            m_quiet;
  int            m_last_enter = 0;
  int            d;

  function automatic int exp_idx();
    if (m_phase == 1) return q1.size();
    if (m_phase == 2) return q2.size();
    return 0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
        key_pipe[k][0] = 1'b1;
        key_pipe[k][1] = 1'b1;
        deb[k] = 1'b1;
        run[k] = 0;
      end
      sw_pipe[0] = 4'd0;
      sw_pipe[1] = 4'd0;
      q1.delete();
      q2.delete();
      m_phase = 0; m_busy = 0; m_done = 0; m_fail = 0;
      m_checking = 0; m_finishing = 0; m_quiet = 0;
      m_code = CW'(32'h0000_1009);
    end else begin
      // A key level is accepted after DEB consecutive cycles of disagreement.
      for (int k = 0; k < 2; k++) begin
        pr[k] = 1'b0;
        if (key_pipe[k][1] != deb[k]) begin
          run[k]++;
          if (run[k] == DEB) begin
            deb[k] = key_pipe[k][1];
            run[k] = 0;
            pr[k]  = (key_pipe[k][1] == 1'b0);
          end
        end else begin
          run[k] = 0;
        end
      end
      d = int'(sw_pipe[1]);
      m_done = 0;
      m_fail = 0;
      if (m_finishing) begin
        m_finishing = 0;
        m_busy = 0;
      end else if (m_checking) begin
        m_checking = 0;
        m_finishing = 1;
        m_eq = 1;
        for (int i = 0; i < DIGITS; i++) if (q1[i] != q2[i]) m_eq = 0;
        if (m_eq) begin
          m_code = '0;
          for (int i = 0; i < DIGITS; i++) m_code = m_code | (CW'(q1[i]) << (4 * i));
          m_done = 1;
        end else begin
          m_fail = 1;
        end
      end else if (m_phase == 0) begin
        if (pr[0]) begin
          m_busy = 1;
          if (unlock_ok) begin
            m_phase = 1;
            q1.delete();
            q2.delete();
            m_quiet = 0;
          end else begin
            m_fail = 1;
            m_finishing = 1;
          end
        end
      end else begin
        if (pr[0]) begin
          m_phase = 0; m_fail = 1; m_finishing = 1;
        end else if (pr[1]) begin
          m_last_enter = cyc - 1;
          m_quiet = 0;
          if (d > 9) begin
            m_phase = 0; m_fail = 1; m_finishing = 1;
          end else if (m_phase == 1) begin
            q1.push_back(d);
            if (q1.size() == DIGITS) m_phase = 2;
          end else begin
            q2.push_back(d);
            if (q2.size() == DIGITS) begin
              m_phase = 0;
              m_checking = 1;
            end
          end
        end
`ifdef CODE_ENROLL_TIMEOUT_EN
        else begin
          m_quiet++;
          if (m_quiet == TMO) begin
            m_phase = 0; m_fail = 1; m_finishing = 1;
          end
        end
`endif
      end
      key_pipe[0][1] = key_pipe[0][0];
      key_pipe[0][0] = key_prog;
      key_pipe[1][1] = key_pipe[1][0];
      key_pipe[1][0] = key_enter;
      sw_pipe[1]     = sw_pipe[0];
      sw_pipe[0]     = sw_digit;
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_done = 0;
  int n_fail = 0;
  int done_cyc = 0;

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("code_out",    32'(code_out),    32'(m_code));
      check("busy",        32'(busy),        32'(m_busy));
      check("phase",       32'(phase),       32'(m_phase));
      check("digit_idx",   32'(digit_idx),   32'(exp_idx()));
      check("enroll_done", 32'(enroll_done), 32'(m_done));
      check("enroll_fail", 32'(enroll_fail), 32'(m_fail));
      if (enroll_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (enroll_fail) n_fail++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_prog();
    key_prog = 1'b0; tick(8);
    key_prog = 1'b1; tick(8);
  endtask

  task automatic enter_digit(input logic [3:0] v);
    sw_digit = v; tick(3);
    key_enter = 1'b0; tick(8);
    key_enter = 1'b1; tick(8);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < DIGITS; i++) begin
      logic [15:0] t;
      t = c >> (4 * i);
      enter_digit(t[3:0]);
    end
  endtask

  int f0, d0;

  initial begin
    reset = 1'b0; key_prog = 1'b1; key_enter = 1'b1; sw_digit = 4'd0; unlock_ok = 1'b0;
    tick(2);
    reset = 1'b1;
    check("rst_code",  32'(code_out), 32'h1009);
    check("rst_busy",  32'(busy), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_idx",   32'(digit_idx), 0);
    check("rst_pulse", 32'({enroll_done, enroll_fail}), 0);
    tick(4);

    // Mismatched second entry: 2,0,1,7 then 2,0,1,8 (digit 0 first).
    unlock_ok = 1'b1;
    f0 = n_fail; d0 = n_done;
    press_prog();
    check("prog_phase", 32'(phase), 1);
    enter_code(16'h7102);
    check("entry2_phase", 32'(phase), 2);
    check("entry2_idx",   32'(digit_idx), 0);
    enter_code(16'h8102);
    tick(4);
    check("mismatch_fail_cnt", 32'(n_fail - f0), 1);
    check("mismatch_done_cnt", 32'(n_done - d0), 0);
    check("mismatch_code",     32'(code_out), 32'h1009);
    check("mismatch_model",    32'(m_code), 32'h1009);

    // Matching entries commit 16'h7102.
    f0 = n_fail; d0 = n_done;
    press_prog();
    enter_code(16'h7102);
    enter_code(16'h7102);
    tick(4);
    check("commit_done_cnt", 32'(n_done - d0), 1);
    check("commit_fail_cnt", 32'(n_fail - f0), 0);
    check("commit_code",     32'(code_out), 32'h7102);
    check("commit_model",    32'(m_code), 32'h7102);
    check("commit_latency",  32'(done_cyc - m_last_enter), 2);
    check("commit_busy",     32'(busy), 0);

    // Glitch on key_enter, then an out-of-range digit.
    f0 = n_fail;
    press_prog();
    enter_digit(4'd3);
    key_enter = 1'b0; tick(3);
    key_enter = 1'b1; tick(10);
    check("glitch_idx", 32'(digit_idx), 1);
    enter_digit(4'hA);
    tick(2);
    check("bad_digit_fail", 32'(n_fail - f0), 1);
    check("bad_digit_code", 32'(code_out), 32'h7102);
    check("bad_digit_busy", 32'(busy), 0);

    // Refusal while locked.
    unlock_ok = 1'b0;
    f0 = n_fail;
    press_prog();
    check("refuse_fail", 32'(n_fail - f0), 1);
    check("refuse_busy", 32'(busy), 0);
    unlock_ok = 1'b1;

    // prog and enter pressed together in ENTRY2: prog wins.
    f0 = n_fail;
    press_prog();
    enter_code(16'h4321);
    enter_digit(4'd5);
    sw_digit = 4'd6; tick(3);
    key_prog = 1'b0; key_enter = 1'b0; tick(8);
    key_prog = 1'b1; key_enter = 1'b1; tick(8);
    check("both_fail", 32'(n_fail - f0), 1);
    check("both_busy", 32'(busy), 0);
    check("both_code", 32'(code_out), 32'h7102);

    // Reset after three digits of ENTRY2.
    press_prog();
    enter_code(16'h4321);
    enter_digit(4'd5); enter_digit(4'd6); enter_digit(4'd7);
    check("pre_rst_phase", 32'(phase), 2);
    check("pre_rst_idx",   32'(digit_idx), 3);
    reset = 1'b0; tick(2);
    reset = 1'b1;
    check("mid_rst_code", 32'(code_out), 32'h1009);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_phase", 32'(phase), 0);
    tick(4);

    // Inactivity in ENTRY1.
    f0 = n_fail;
    press_prog();
    tick(150);
`ifdef CODE_ENROLL_TIMEOUT_EN
    check("timeout_fail", 32'(n_fail - f0), 1);
    check("timeout_busy", 32'(busy), 0);
`else
    check("no_timeout_fail",  32'(n_fail - f0), 0);
    check("no_timeout_phase", 32'(phase), 1);
    press_prog();
    check("abort_fail", 32'(n_fail - f0), 1);
    check("abort_busy", 32'(busy), 0);
`endif
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
